// File: rtl/timer_bank.sv
// timer_bank: prescaled up-counting timers with auto-reload/one-shot and W1C interrupts,
// memory-mapped per channel plus global STATUS/ID registers.
module timer_bank #(
  parameter int NUM_TIMERS = 4,
  parameter int CNT_WIDTH = 32,
  parameter int PRE_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);
  logic [CNT_WIDTH-1:0] reload [NUM_TIMERS];
  logic [CNT_WIDTH-1:0] count [NUM_TIMERS];
  logic [PRE_WIDTH-1:0] prescale [NUM_TIMERS];
  logic [PRE_WIDTH-1:0] pre_cnt [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] en, ie, pend, oneshot;
  logic [NUM_TIMERS-1:0] hit, wr_rel, wr_cnt, wr_ctl, wr_pre, tick, ovf, clr;
  logic [31:0] off;
  logic ch_hit, st_hit, id_hit;
  assign off = addr - BASE_ADDR;
  assign ch_hit = off < 32'(16 * NUM_TIMERS) && off[1:0] == 2'b00;
  assign st_hit = off == 32'h100;
  assign id_hit = off == 32'h104;
  assign irqout = |(pend & ie);
  // A COUNT write suppresses the overflow of a tick landing on the same edge.
  always_comb begin
    hit = '0;
    wr_rel = '0;
    wr_cnt = '0;
    wr_ctl = '0;
    wr_pre = '0;
    tick = '0;
    ovf = '0;
    clr = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      hit[i] = ch_hit && off[6:4] == 3'(i);
      wr_rel[i] = wr && hit[i] && off[3:2] == 2'd0;
      wr_cnt[i] = wr && hit[i] && off[3:2] == 2'd1;
      wr_ctl[i] = wr && hit[i] && off[3:2] == 2'd2;
      wr_pre[i] = wr && hit[i] && off[3:2] == 2'd3;
      tick[i] = en[i] && pre_cnt[i] == prescale[i];
      ovf[i] = tick[i] && &count[i] && !wr_cnt[i];
      clr[i] = (wr_ctl[i] && wdata[2]) || (wr && st_hit && wdata[i]);
    end
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_TIMERS; i++)
      if (rd && hit[i])
        rdata = off[3:2] == 2'd0 ? 32'(reload[i]) :
                off[3:2] == 2'd1 ? 32'(count[i]) :
                off[3:2] == 2'd2 ? {28'd0, oneshot[i], pend[i], ie[i], en[i]} : 32'(prescale[i]);
    if (rd && st_hit) rdata = 32'(pend);
    if (rd && id_hit) rdata = {16'h7B01, 8'(CNT_WIDTH), 8'(NUM_TIMERS)};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        reload[i] <= '0;
        count[i] <= '0;
        prescale[i] <= '0;
        pre_cnt[i] <= '0;
      end
      en <= '0;
      ie <= '0;
      pend <= '0;
      oneshot <= '0;
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (wr_rel[i]) reload[i] <= wdata[CNT_WIDTH-1:0];
        if (wr_pre[i]) prescale[i] <= wdata[PRE_WIDTH-1:0];
        count[i] <= wr_cnt[i] ? wdata[CNT_WIDTH-1:0] : ovf[i] ? reload[i] :
                    tick[i] ? count[i] + CNT_WIDTH'(1) : count[i];
        pre_cnt[i] <= (!en[i] || wr_pre[i] || wr_cnt[i] || tick[i]) ? '0 : pre_cnt[i] + PRE_WIDTH'(1);
        en[i] <= wr_ctl[i] ? wdata[0] : (ovf[i] && oneshot[i]) ? 1'b0 : en[i];
        ie[i] <= wr_ctl[i] ? wdata[1] : ie[i];
        oneshot[i] <= wr_ctl[i] ? wdata[3] : oneshot[i];
        pend[i] <= ovf[i] | (pend[i] & ~clr[i]);
      end
    end
endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel timer block for the memory-mapped peripheral bus of the single-cycle/pipelined MIPS CPU. It provides `NUM_TIMERS` independent up-counting timers, each with a reload value, a programmable prescaler, auto-reload or one-shot mode, and a per-channel interrupt with write-1-to-clear pending bits. All pending-and-enabled interrupts are ORed onto a single `irqout` line to the CPU.

## Interface
- `NUM_TIMERS`, 4: channel count, legal range 1..8.
- `CNT_WIDTH`, 32: RELOAD/COUNT width, legal range 8..32.
- `PRE_WIDTH`, 8: prescaler width, legal range 1..16.
- `BASE_ADDR`, 32'h40000000: byte address of channel 0.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `rd`  in  1  read strobe.
- `wr`  in  1  write strobe, sampled at the rising edge of `clk`.
- `addr`  in  32  byte address; exact match required.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational.
- `irqout`  out  1  OR over channels of (PEND & IE).

## Operation
- Channel i is at `BASE_ADDR + 0x10*i`:
  - +0x0 RELOAD (R/W)
  - +0x4 COUNT (R/W)
  - +0x8 CTRL (R/W)
  - +0xC PRESCALE (R/W)
- Global registers:
  - `BASE_ADDR+0x100` STATUS (R/W1C): bit i = PEND of channel i, upper bits 0.
  - `BASE_ADDR+0x104` ID (RO): {16'h7B01, 8'(CNT_WIDTH), 8'(NUM_TIMERS)}.
- CTRL bits: [0] EN, [1] IE, [2] PEND (W1C), [3] ONESHOT. Bits [31:4] read 0 and are ignored on write.
- Width rules:
  - Writes to RELOAD/COUNT/PRESCALE take the low bits of `wdata`.
  - Reads are zero-extended.
  - Unmapped addresses and channels ≥ `NUM_TIMERS` read 0; writes to them are ignored.
  - `rdata` = 0 whenever `rd`=0.
- Prescaler, per channel, internal `pre_cnt`:
  - While EN=1, `pre_cnt` increments each cycle.
  - When `pre_cnt == PRESCALE`, a tick is generated and `pre_cnt` returns to 0.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=p gives a tick every p+1 cycles.
  - `pre_cnt` is cleared when EN=0 and on any write to PRESCALE or COUNT.
- On a tick:
  - If COUNT ≠ all-ones: COUNT ← COUNT+1.
  - If COUNT = all-ones (overflow): COUNT ← RELOAD and PEND ← 1. If ONESHOT=1, EN ← 0 on the same edge.
- PEND is set regardless of IE; IE only gates `irqout`.
- Clearing PEND: write 1 to CTRL[2] of the channel, or write 1 to the matching STATUS bit. Writing 0 has no effect.
- Simultaneous events:
  - A COUNT write in the same cycle as a tick: the write wins and no overflow is generated that cycle.
  - A CTRL write sets EN/IE/ONESHOT as written. PEND follows the W1C rule.
  - A hardware PEND set in the same cycle as a W1C clear: the set wins, PEND = 1.
  - A CTRL write of EN=1 in the same cycle as a one-shot overflow: the write wins, EN = 1.
- Reset: all RELOAD, COUNT, CTRL, PRESCALE and `pre_cnt` are 0. `irqout` = 0; `rdata` = 0 while `rd`=0.
- Reset mid-count aborts immediately; no interrupt is produced.

## Timing
- Register write latency: 1 edge. The new value is visible on `rdata` in the cycle after the `wr` edge.
- With PRESCALE=0 and EN written to 1 at edge E0, the first increment occurs at edge E1.
- Overflow at edge En updates COUNT and PEND on that same edge. `irqout` rises combinationally after En, provided IE=1.
- `irqout` falls in the cycle after the clearing write edge, unless re-set on that edge.
- No bus wait states; reads are single-cycle combinational.

## Test plan
- Reset and defaults:
  - Stimulus: assert reset mid-run, then read every register.
  - Required: all 0 except ID = 32'h7B01_2004 for defaults; `irqout` = 0.
- Auto-reload overflow:
  - Stimulus: ch0 RELOAD=0xFFFFFFF0, COUNT=0xFFFFFFFC, PRESCALE=0, CTRL=0x3.
  - Required: COUNT reaches 0xFFFFFFFF after 3 edges; on the 4th edge COUNT=0xFFFFFFF0 and PEND=1; `irqout`=1; STATUS=0x1.
- One-shot and prescale:
  - Stimulus: ch2 PRESCALE=2, COUNT=0xFFFFFFFE, CTRL=0xB.
  - Required: COUNT increments every 3 cycles; after 6 cycles PEND=1 and EN=0; COUNT=RELOAD and holds.
- W1C collision:
  - Stimulus: write STATUS=0x1 on the exact edge ch0 overflows.
  - Required: PEND stays 1. A W1C one cycle later clears it, and `irqout` drops the next cycle.
- Multi-channel independence:
  - Stimulus: ch1 with IE=0 and ch3 with IE=1 both overflow.
  - Required: STATUS=0xA; `irqout` driven by ch3 only; clearing bit 3 drops `irqout` while bit 1 stays.
- Bus edge cases:
  - Stimulus: read `BASE_ADDR+0x40` (channel 4, not present), read `BASE_ADDR+0x10C` (unmapped), write to both, read with `rd`=0.
  - Required: all reads return 0 and no register state changes.
